row_pack_mdl: RTL and testbench

Upstream feeder for rowBuff_mdl. Accepts a serial stream of DATA_SIZE-bit elements with a valid/ready handshake and packs ROW_SIZE elements into one row word. It issues rows with a valid/ready handshake. After COLUMN_SIZE rows, or on an early frame-end marker, it issues a frame-end beat (rowEnd) that drives the downstream dendFlag. rowValid drives the downstream enable.

---
 rtl/row_pack_mdl_if.sv | 35 +++
 rtl/row_pack_mdl.sv | 119 +++++++++++
 tb/tb_row_pack_mdl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/row_pack_mdl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : row_pack_mdl_if
//  Brief    : Element-in / row-out handshake bundle for row_pack_mdl.
//  Revision : 1.0
// ============================================================================
interface row_pack_mdl_if #(
   parameter int DATA_SIZE   = 16,
   parameter int ROW_SIZE    = 16,
   parameter int COLUMN_SIZE = 16
);
   localparam int c_CNT_W = $clog2(COLUMN_SIZE) + 1;

   logic                          inValid;
   logic                          inReady;
   logic [DATA_SIZE-1:0]          inData;
   logic                          inLast;
   logic                          rowValid;
   logic                          outReady;
   logic [DATA_SIZE*ROW_SIZE-1:0] rowData;
   logic                          rowEnd;
   logic [c_CNT_W-1:0]            rowCount;

   modport master (
      output inValid, inData, inLast, outReady,
      input  inReady, rowValid, rowData, rowEnd, rowCount
   );

   modport slave (
      input  inValid, inData, inLast, outReady,
      output inReady, rowValid, rowData, rowEnd, rowCount
   );
endinterface
`default_nettype wire

// File: rtl/row_pack_mdl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : row_pack_mdl
//  Brief    : Packs ROW_SIZE serial elements into a row word and emits a
//             frame-end beat after COLUMN_SIZE rows or an inLast marker.
//  Revision : 1.0
// ============================================================================
module row_pack_mdl #(
   parameter int DATA_SIZE   = 16,
   parameter int ROW_SIZE    = 16,
   parameter int COLUMN_SIZE = 16
) (
   input  wire logic        clock,
   input  wire logic        reset,
   input  wire logic        enable,
   row_pack_mdl_if.slave    bus
);

   localparam int c_CNT_W  = $clog2(COLUMN_SIZE) + 1;
   localparam int c_LANE_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int c_ROW_W  = DATA_SIZE * ROW_SIZE;

   localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(ROW_SIZE - 1);
   localparam logic [c_CNT_W-1:0]  c_LAST_ROW  = c_CNT_W'(COLUMN_SIZE - 1);

   localparam logic [1:0] c_FILL = 2'd0;
   localparam logic [1:0] c_EMIT = 2'd1;
   localparam logic [1:0] c_ENDF = 2'd2;

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [c_LANE_W-1:0] lane_q;
   logic [c_CNT_W-1:0]  rowCount_q;
   logic [c_ROW_W-1:0]  rowData_q;
   logic                lastPending_q;

   logic                w_inReady;
   logic                w_rowValid;
   logic                w_in_acc;
   logic                w_beat_acc;
   logic                w_row_done;

   assign w_in_acc   = w_inReady & bus.inValid;
   assign w_beat_acc = w_rowValid & bus.outReady;
   assign w_row_done = (lane_q == c_LAST_LANE) | bus.inLast;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= c_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_FILL: if (w_in_acc && w_row_done) state_d = c_EMIT;
         c_EMIT: if (w_beat_acc) state_d = lastPending_q ? c_ENDF : c_FILL;
         c_ENDF: if (w_beat_acc) state_d = c_FILL;
         default: state_d = c_FILL;
      endcase
   end

   // Handshake outputs depend only on state and enable, never on the peer's strobe.
   always_comb begin
      w_inReady  = 1'b0;
      w_rowValid = 1'b0;
      if (reset && enable) begin
         case (state_q)
            c_FILL:         w_inReady  = 1'b1;
            c_EMIT, c_ENDF: w_rowValid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lane_q        <= '0;
         rowCount_q    <= '0;
         rowData_q     <= '0;
         lastPending_q <= 1'b0;
      end else begin
         if (w_in_acc) begin
            for (int k = 0; k < ROW_SIZE; k++) begin
               if (lane_q == c_LANE_W'(k)) begin
                  rowData_q[k*DATA_SIZE +: DATA_SIZE] <= bus.inData;
               end
            end
            if (w_row_done) begin
               lane_q        <= '0;
               lastPending_q <= bus.inLast | (rowCount_q == c_LAST_ROW);
            end else begin
               lane_q <= lane_q + c_LANE_W'(1);
            end
         end
         // Clearing on every accepted beat gives zero-padded short rows and a zero ENDF word.
         if (w_beat_acc) begin
            rowData_q <= '0;
            if (state_q == c_ENDF) begin
               rowCount_q    <= '0;
               lastPending_q <= 1'b0;
            end else begin
               rowCount_q <= rowCount_q + c_CNT_W'(1);
            end
         end
      end
   end

   assign bus.inReady  = w_inReady;
   assign bus.rowValid = w_rowValid;
   assign bus.rowData  = rowData_q;
   assign bus.rowEnd   = (state_q == c_ENDF);
   assign bus.rowCount = rowCount_q;

endmodule
`default_nettype wire

// File: tb/tb_row_pack_mdl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_row_pack_mdl
//  Brief    : Directed and random stimulus for row_pack_mdl against a
//             queue-based row/frame reference model.
//  Revision : 1.0
// ============================================================================
module tb_row_pack_mdl;

   localparam int DW = 8;
   localparam int RS = 4;
   localparam int CS = 3;
   localparam int RW = DW * RS;

   typedef struct packed {
      logic [RW-1:0] data;
      logic          endf;
   } beat_t;

   logic clock  = 1'b0;
   logic reset  = 1'b0;
   logic enable = 1'b0;

   always #5 clock = ~clock;

   row_pack_mdl_if #(.DATA_SIZE(DW), .ROW_SIZE(RS), .COLUMN_SIZE(CS)) bus ();

   row_pack_mdl #(.DATA_SIZE(DW), .ROW_SIZE(RS), .COLUMN_SIZE(CS)) dut (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .bus    (bus.slave)
   );

   beat_t         exp_q[$];
   logic [DW-1:0] row_elems[$];
   int            rows_in_frame = 0;
   int            exp_count     = 0;
   int            end_beats     = 0;
   logic [RW-1:0] last_row      = '0;
   bit            last_acc      = 1'b0;
   int            checks        = 0;
   int            failures      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=completion", tag);
   endtask

   function automatic logic [RW-1:0] pack_partial();
      logic [RW-1:0] p = '0;
      foreach (row_elems[k]) p[k*DW +: DW] = row_elems[k];
      return p;
   endfunction

   function automatic void model_push(input logic [DW-1:0] d, input logic last);
      beat_t b;
      row_elems.push_back(d);
      if (row_elems.size() == RS || last) begin
         b.data = pack_partial();
         b.endf = 1'b0;
         exp_q.push_back(b);
         rows_in_frame++;
         row_elems.delete();
         if (last || rows_in_frame == CS) begin
            b.data = '0;
            b.endf = 1'b1;
            exp_q.push_back(b);
            rows_in_frame = 0;
         end
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      row_elems.delete();
      rows_in_frame = 0;
      exp_count     = 0;
   endfunction

   // Called at posedge+1 with inputs set; checks, updates the model, ends at next posedge+1.
   task automatic step();
      bit    en;
      beat_t b;
      en = enable && reset;
      #1;
      chk("rowValid", 32'(bus.rowValid), 32'(en && exp_q.size() > 0));
      chk("inReady",  32'(bus.inReady),  32'(en && exp_q.size() == 0));
      chk("rowCount", 32'(bus.rowCount), 32'(exp_count));
      if (exp_q.size() > 0) begin
         chk("rowData_beat", bus.rowData, exp_q[0].data);
         chk("rowEnd_beat",  32'(bus.rowEnd), 32'(exp_q[0].endf));
      end else begin
         chk("rowData_fill", bus.rowData, pack_partial());
         chk("rowEnd_fill",  32'(bus.rowEnd), 32'd0);
      end
      last_acc = 1'b0;
      if (en && bus.rowValid && bus.outReady && exp_q.size() > 0) begin
         b = exp_q.pop_front();
         if (b.endf) begin
            exp_count = 0;
            end_beats++;
         end else begin
            exp_count++;
            last_row = b.data;
         end
      end
      if (en && bus.inValid && bus.inReady) begin
         model_push(bus.inData, bus.inLast);
         last_acc = 1'b1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic last);
      bus.inValid = 1'b1;
      bus.inData  = d;
      bus.inLast  = last;
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_acc) break;
      end
      if (!last_acc) timeout_fail("send_timeout");
   endtask

   task automatic drain();
      bus.inValid  = 1'b0;
      bus.inLast   = 1'b0;
      bus.outReady = 1'b1;
      enable       = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
      step();
      if (exp_q.size() > 0) timeout_fail("drain_timeout");
   endtask

   initial begin
      bit pend;
      bus.inValid  = 1'b0;
      bus.inData   = '0;
      bus.inLast   = 1'b0;
      bus.outReady = 1'b1;
      enable       = 1'b1;
      @(posedge clock);
      #1;

      // Reset held, then released into idle
      step();
      step();
      reset = 1'b1;
      step();
      step();

      // Full frame of three rows without inLast
      for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
      drain();
      chk("frame_last_row", last_row, 32'h0C0B0A09);
      chk("frame_end_beats", 32'(end_beats), 32'd1);

      // Early frame end with short, zero-padded second row
      for (int i = 'h11; i <= 'h16; i++) send(8'(i), i == 'h16);
      drain();
      chk("short_last_row", last_row, 32'h00001615);
      chk("short_end_beats", 32'(end_beats), 32'd2);

      // Downstream stall during EMIT with an element waiting upstream
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
      bus.inValid  = 1'b1;
      bus.inData   = 8'h55;
      bus.inLast   = 1'b1;
      bus.outReady = 1'b0;
      repeat (5) step();
      bus.inValid  = 1'b0;
      bus.outReady = 1'b1;
      step();
      chk("stall_release_row", last_row, 32'h04030201);
      send(8'h55, 1'b1);
      drain();
      chk("lane0_last_row", last_row, 32'h00000055);
      chk("lane0_end_beats", 32'(end_beats), 32'd3);

      // Enable dropped mid-row with the next element offered
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      bus.inData = 8'h03;
      enable     = 1'b0;
      repeat (3) step();
      enable = 1'b1;
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      drain();
      chk("enable_resume_row", last_row, 32'h04030201);

      // Asynchronous reset after two rows plus two elements
      for (int i = 'h31; i <= 'h34; i++) send(8'(i), 1'b0);
      drain();
      send(8'h35, 1'b0);
      send(8'h36, 1'b0);
      bus.inValid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      chk("async_rowValid", 32'(bus.rowValid), 32'd0);
      chk("async_rowEnd",   32'(bus.rowEnd),   32'd0);
      chk("async_rowCount", 32'(bus.rowCount), 32'd0);
      chk("async_rowData",  bus.rowData,       32'd0);
      chk("async_inReady",  32'(bus.inReady),  32'd0);
      model_reset();
      @(posedge clock);
      #1;
      step();
      reset = 1'b1;
      for (int i = 'hA1; i <= 'hA4; i++) send(8'(i), 1'b0);
      drain();
      chk("post_reset_row", last_row, 32'hA4A3A2A1);
      chk("post_reset_count", 32'(bus.rowCount), 32'd1);

      // Random traffic with enable, backpressure and inLast
      pend = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (!pend || last_acc) begin
            bus.inData = 8'($urandom_range(0, 255));
            bus.inLast = ($urandom_range(0, 7) == 0);
            pend = 1'b1;
         end
         bus.inValid  = ($urandom_range(0, 3) != 0);
         bus.outReady = ($urandom_range(0, 3) != 0);
         enable       = ($urandom_range(0, 9) != 0);
         step();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
